// File: rtl/uart_pkg.sv
// uart_pkg: framing constants and receiver state encoding shared by both UART ends
package uart_pkg;
  localparam int UART_DATA_BITS = 8;
  localparam int UART_CLKS_PER_BIT = 16;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_state_t;
endpackage

// File: rtl/uart_sync.sv
// uart_sync: 2-flop synchronizer for an asynchronous input, with a selectable reset value
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clock or posedge reset)
    if (reset) {q, meta} <= {RST_VAL, RST_VAL};
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with mid-bit sampling, byte strobe and framing-error pulse
module uart_rx import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] data_out,
  output logic                      rx_done,
  output logic                      frame_err,
  output logic                      busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(UART_DATA_BITS - 1);
  uart_state_t state;
  logic rx_s;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [UART_DATA_BITS-1:0] shreg;
  uart_sync #(.RST_VAL(1'b1)) u_sync (.clock(clock), .reset(reset), .d(rx), .q(rx_s));
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shreg <= '0;
      data_out <= '0;
      rx_done <= 1'b0;
      frame_err <= 1'b0;
      busy <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state <= START;
            busy <= 1'b1;
          end
        end
        START:
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            idx <= '0;
            state <= rx_s ? IDLE : DATA;
            busy <= !rx_s;
          end else cnt <= cnt + 1'b1;
        DATA:
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            shreg <= {rx_s, shreg[UART_DATA_BITS-1:1]};
            idx <= idx + 1'b1;
            if (idx == IDX_LAST) state <= STOP;
          end else cnt <= cnt + 1'b1;
        STOP:
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              data_out <= shreg;
              rx_done <= 1'b1;
              state <= IDLE;
              busy <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state <= BREAK;
            end
          end else cnt <= cnt + 1'b1;
        BREAK: begin
          // a held-low line must return high before another start can be seen
          cnt <= '0;
          if (rx_s) begin
            state <= IDLE;
            busy <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against uart_rx with hand-computed expectations
module tb_uart_rx;
  localparam int CPB = 16;
  logic clock = 1'b0;
  logic reset;
  logic rx;
  logic [7:0] data_out;
  logic rx_done, frame_err, busy;
  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int done_cnt = 0;
  int ferr_cnt = 0;
  int both_cnt = 0;
  int done_cyc[$];
  logic [7:0] done_val[$];
  int d0, f0, n;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clock(clock), .reset(reset), .rx(rx), .data_out(data_out),
    .rx_done(rx_done), .frame_err(frame_err), .busy(busy)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    cycle++;
    if (rx_done) begin
      done_cnt++;
      done_cyc.push_back(cycle);
      done_val.push_back(data_out);
    end
    if (frame_err) ferr_cnt++;
    if (rx_done && frame_err) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic b, input int cycles);
    rx = b;
    repeat (cycles) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(d[i], CPB);
    hold(stop, CPB);
  endtask

  initial begin
    reset = 1'b1;
    rx = 1'b1;
    repeat (3) @(negedge clock);
    chk("reset_data_out", 32'(data_out), 32'h00);
    chk("reset_rx_done", 32'(rx_done), 32'h0);
    chk("reset_frame_err", 32'(frame_err), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    hold(1'b1, 5);

    d0 = done_cnt; f0 = ferr_cnt;
    send_frame(8'hC9, 1'b1);
    hold(1'b1, 4);
    chk("single_done_count", 32'(done_cnt - d0), 32'd1);
    chk("single_data", 32'(data_out), 32'hC9);
    chk("single_no_ferr", 32'(ferr_cnt - f0), 32'd0);
    chk("single_busy_low", 32'(busy), 32'h0);

    d0 = done_cnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    hold(1'b1, 4);
    chk("b2b_done_count", 32'(done_cnt - d0), 32'd2);
    n = done_cyc.size();
    if (n >= 2) begin
      chk("b2b_spacing", 32'(done_cyc[n-1] - done_cyc[n-2]), 32'(10 * CPB));
      chk("b2b_first", 32'(done_val[n-2]), 32'h00);
      chk("b2b_second", 32'(done_val[n-1]), 32'hFF);
    end else chk("b2b_pulses_logged", 32'(n), 32'd2);

    d0 = done_cnt; f0 = ferr_cnt;
    hold(1'b0, 3);
    hold(1'b1, 2);
    chk("glitch_busy_high", 32'(busy), 32'h1);
    hold(1'b1, CPB / 2 + 3 - 5);
    chk("glitch_busy_low", 32'(busy), 32'h0);
    hold(1'b1, 2 * CPB);
    chk("glitch_no_pulse", 32'(done_cnt - d0 + ferr_cnt - f0), 32'd0);
    chk("glitch_data_kept", 32'(data_out), 32'hFF);

    d0 = done_cnt; f0 = ferr_cnt;
    send_frame(8'h5A, 1'b0);
    hold(1'b0, 4);
    chk("ferr_pulse", 32'(ferr_cnt - f0), 32'd1);
    chk("ferr_busy_in_break", 32'(busy), 32'h1);
    hold(1'b0, 20 * CPB);
    chk("ferr_single_pulse", 32'(ferr_cnt - f0), 32'd1);
    chk("ferr_no_done", 32'(done_cnt - d0), 32'd0);
    chk("ferr_data_kept", 32'(data_out), 32'hFF);
    hold(1'b1, 5);
    chk("ferr_busy_released", 32'(busy), 32'h0);

    d0 = done_cnt; f0 = ferr_cnt;
    hold(1'b0, CPB);
    for (int i = 0; i < 4; i++) hold(i[0] ? 1'b0 : 1'b1, CPB);
    hold(1'b0, CPB / 2);
    reset = 1'b1;
    #1;
    chk("midreset_data_out", 32'(data_out), 32'h00);
    chk("midreset_busy", 32'(busy), 32'h0);
    rx = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    hold(1'b1, 2 * CPB);
    chk("midreset_no_pulse", 32'(done_cnt - d0 + ferr_cnt - f0), 32'd0);
    send_frame(8'h3C, 1'b1);
    hold(1'b1, 4);
    chk("after_reset_done", 32'(done_cnt - d0), 32'd1);
    chk("after_reset_data", 32'(data_out), 32'h3C);
    chk("never_both_pulses", 32'(both_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
